// File: rtl/board_input_conditioner.sv
// board_input_conditioner
// Conditions asynchronous board inputs (UART RX, buttons, DIP switches, card-detect) into the
// core clock domain. Each channel has a synchroniser chain and a glitch filter that accepts a
// new level only after it has persisted FILTER_CYCLES synchronised cycles. It also produces
// one-cycle rise/fall pulses on accepted changes and a saturating count of rejected glitches.
//
// Ports:
//   clk          core clock, rising edge
//   reset        synchronous, active-high
//   pin_in       raw asynchronous inputs, one bit per channel
//   glitch_clr   synchronous clear of glitch_count
//   level_out    filtered, synchronised level (registered)
//   rise         one-cycle pulse on an accepted 0->1 change (registered)
//   fall         one-cycle pulse on an accepted 1->0 change (registered)
//   glitch_count saturating count of cycles with at least one rejected glitch (registered)
module board_input_conditioner #(
   parameter int unsigned      WIDTH         = 4,
   parameter int unsigned      SYNC_STAGES   = 2,
   parameter int unsigned      FILTER_CYCLES = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pin_in,
   input  logic             glitch_clr,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [7:0]       glitch_count
);

   localparam int unsigned     CntW    = $clog2(FILTER_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_cur;

   logic [CntW-1:0]  cnt_q [WIDTH];
   logic [CntW-1:0]  cnt_d [WIDTH];
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] reject;
   logic [7:0]       glitch_q, glitch_d;

   assign sync_cur = sync_q[SYNC_STAGES-1];

   // Synchroniser chains; reset preloads the idle level so release produces no edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= RESET_VALUE;
         end
      end else begin
         sync_q[0] <= pin_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   // Per-channel filter. cnt counts consecutive cycles the synchronised input has disagreed
   // with level_out; a disagreement that ends before acceptance is a rejected glitch.
   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      reject  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_cur[i] == level_q[i]) begin
            cnt_d[i]  = '0;
            reject[i] = (cnt_q[i] != '0);
         end else if (cnt_q[i] == CntLast) begin
            level_d[i] = sync_cur[i];
            cnt_d[i]   = '0;
            rise_d[i]  = sync_cur[i];
            fall_d[i]  = ~sync_cur[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
   end

   // One increment per cycle however many channels rejected; clear has priority.
   always_comb begin
      glitch_d = glitch_q;
      if (glitch_clr) begin
         glitch_d = '0;
      end else if ((|reject) && (glitch_q != 8'hFF)) begin
         glitch_d = glitch_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         level_q  <= RESET_VALUE;
         rise_q   <= '0;
         fall_q   <= '0;
         glitch_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         level_q  <= level_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign level_out    = level_q;
   assign rise         = rise_q;
   assign fall         = fall_q;
   assign glitch_count = glitch_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// tb_board_input_conditioner
// Drives three conditioner instances (defaults, SYNC_STAGES=3/FILTER_CYCLES=4, and
// SYNC_STAGES=3/FILTER_CYCLES=8, all with RESET_VALUE=4'b1010) from shared stimulus.
// A window-based reference model predicts every output each cycle; directed sequences pin
// latency, glitch rejection, saturation, clear priority and reset behaviour with literals.
module tb_board_input_conditioner;

   localparam int         NDut = 3;
   localparam logic [3:0] Rv   = 4'b1010;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] pin_in;
   logic       glitch_clr;

   logic [3:0] d_level [NDut];
   logic [3:0] d_rise  [NDut];
   logic [3:0] d_fall  [NDut];
   logic [7:0] d_gc    [NDut];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   board_input_conditioner #(
      .WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(1), .RESET_VALUE(Rv)
   ) u_a (
      .clk(clk), .reset(reset), .pin_in(pin_in), .glitch_clr(glitch_clr),
      .level_out(d_level[0]), .rise(d_rise[0]), .fall(d_fall[0]), .glitch_count(d_gc[0])
   );

   board_input_conditioner #(
      .WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(4), .RESET_VALUE(Rv)
   ) u_b (
      .clk(clk), .reset(reset), .pin_in(pin_in), .glitch_clr(glitch_clr),
      .level_out(d_level[1]), .rise(d_rise[1]), .fall(d_fall[1]), .glitch_count(d_gc[1])
   );

   board_input_conditioner #(
      .WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(8), .RESET_VALUE(Rv)
   ) u_c (
      .clk(clk), .reset(reset), .pin_in(pin_in), .glitch_clr(glitch_clr),
      .level_out(d_level[2]), .rise(d_rise[2]), .fall(d_fall[2]), .glitch_count(d_gc[2])
   );

   function automatic int syn(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic int flt(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
   endfunction

   // Reference model: a change is accepted when the current synchronised sample and the
   // previous FILTER_CYCLES-1 samples all differ from the accepted level; a glitch is a
   // sample that agrees with the level right after one that disagreed.
   logic [3:0] m_pipe  [NDut][4];
   logic [3:0] m_seen  [NDut][8];
   logic [3:0] m_level [NDut];
   logic [3:0] m_rise  [NDut];
   logic [3:0] m_fall  [NDut];
   logic [7:0] m_gc    [NDut];
   bit         m_valid = 1'b0;

   always @(posedge clk) begin
      logic [3:0] cur, acc, glitch;
      bit         ok;
      if (reset) begin
         for (int d = 0; d < NDut; d++) begin
            for (int k = 0; k < 4; k++) m_pipe[d][k] = Rv;
            for (int j = 0; j < 8; j++) m_seen[d][j] = Rv;
            m_level[d] = Rv;
            m_rise[d]  = '0;
            m_fall[d]  = '0;
            m_gc[d]    = '0;
         end
         m_valid = 1'b1;
      end else if (m_valid) begin
         for (int d = 0; d < NDut; d++) begin
            cur = m_pipe[d][syn(d)-1];
            acc = '0;
            glitch = '0;
            for (int b = 0; b < 4; b++) begin
               ok = (cur[b] != m_level[d][b]);
               for (int j = 0; j < flt(d) - 1; j++) begin
                  if (m_seen[d][j][b] == m_level[d][b]) ok = 1'b0;
               end
               acc[b]    = ok;
               glitch[b] = (cur[b] == m_level[d][b]) && (m_seen[d][0][b] != m_level[d][b]);
            end
            m_rise[d]  = acc & cur;
            m_fall[d]  = acc & ~cur;
            m_level[d] = (m_level[d] & ~acc) | (cur & acc);
            if (glitch_clr) m_gc[d] = '0;
            else if ((glitch != '0) && (m_gc[d] < 8'd255)) m_gc[d] = m_gc[d] + 8'd1;
            for (int j = 7; j > 0; j--) m_seen[d][j] = m_seen[d][j-1];
            m_seen[d][0] = cur;
            for (int k = 3; k > 0; k--) m_pipe[d][k] = m_pipe[d][k-1];
            m_pipe[d][0] = pin_in;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         for (int d = 0; d < NDut; d++) begin
            checks++;
            if ({d_level[d], d_rise[d], d_fall[d], d_gc[d]} !==
                {m_level[d], m_rise[d], m_fall[d], m_gc[d]}) begin
               errors++;
               $display("FAIL model_cmp dut%0d t=%0t got level=%b rise=%b fall=%b gc=%0d, want level=%b rise=%b fall=%b gc=%0d",
                        d, $time, d_level[d], d_rise[d], d_fall[d], d_gc[d],
                        m_level[d], m_rise[d], m_fall[d], m_gc[d]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Advance n cycles, accumulating rise/fall pulses seen on one channel of one instance.
   task automatic watch(input int n, input int d, input int b, inout int nr, inout int nf);
      repeat (n) begin
         @(negedge clk);
         nr += int'(d_rise[d][b]);
         nf += int'(d_fall[d][b]);
      end
   endtask

   initial begin
      int nr, nf;
      pin_in     = 4'b0101;
      reset      = 1'b1;
      glitch_clr = 1'b0;

      // Reset values and first change after release.
      cyc(3);
      chk("rst_level_a", d_level[0], Rv);
      chk("rst_level_b", d_level[1], Rv);
      chk("rst_rise_a", d_rise[0], 4'b0000);
      chk("rst_fall_a", d_fall[0], 4'b0000);
      chk("rst_gc_a", d_gc[0], 8'd0);
      reset = 1'b0;
      cyc(2);
      chk("rel_hold_a", d_level[0], Rv);
      cyc(1);
      chk("rel_level_a", d_level[0], 4'b0101);
      chk("rel_rise_a", d_rise[0], 4'b0101);
      chk("rel_fall_a", d_fall[0], 4'b1010);
      cyc(1);
      chk("rel_pulse_end_a", {d_rise[0], d_fall[0]}, 8'h00);
      cyc(3);
      chk("rel_level_b", d_level[1], 4'b0101);
      chk("rel_fall_b", d_fall[1], 4'b1010);
      cyc(6);

      // Latency on instance b: 3 + 4 edges.
      pin_in = 4'b0100;
      cyc(6);
      chk("lat_hold_b0", d_level[1][0], 1'b1);
      cyc(1);
      chk("lat_level_b0", d_level[1][0], 1'b0);
      chk("lat_fall_b0", d_fall[1][0], 1'b1);
      cyc(1);
      chk("lat_fall_end_b0", d_fall[1][0], 1'b0);
      cyc(8);

      // 3-cycle low pulse on channel 2: rejected by b.
      nr = 0; nf = 0;
      pin_in[2] = 1'b0;
      watch(3, 1, 2, nr, nf);
      pin_in[2] = 1'b1;
      watch(15, 1, 2, nr, nf);
      chk("glitch3_pulses_b2", nr + nf, 0);
      chk("glitch3_level_b2", d_level[1][2], 1'b1);
      chk("glitch3_gc_b", d_gc[1], 8'd1);

      // 4-cycle low pulse: accepted by b, no glitch counted.
      nr = 0; nf = 0;
      pin_in[2] = 1'b0;
      watch(4, 1, 2, nr, nf);
      pin_in[2] = 1'b1;
      watch(20, 1, 2, nr, nf);
      chk("pulse4_fall_b2", nf, 1);
      chk("pulse4_rise_b2", nr, 1);
      chk("pulse4_gc_b", d_gc[1], 8'd1);
      chk("pulse4_gc_c", d_gc[2], 8'd2);

      // Simultaneous glitches on channels 0 and 3 count once.
      pin_in = pin_in ^ 4'b1001;
      cyc(3);
      pin_in = pin_in ^ 4'b1001;
      cyc(12);
      chk("simul_gc_b", d_gc[1], 8'd2);
      chk("simul_level_b", d_level[1], 4'b0100);

      // Saturation.
      for (int g = 0; g < 300; g++) begin
         pin_in[1] = 1'b1;
         cyc(3);
         pin_in[1] = 1'b0;
         cyc(3);
      end
      chk("sat_gc_b", d_gc[1], 8'hFF);
      cyc(10);
      chk("sat_hold_gc_b", d_gc[1], 8'hFF);
      chk("sat_level_b", d_level[1][1], 1'b0);

      // Clear in the same cycle as a rejection.
      pin_in[1] = 1'b1;
      cyc(3);
      pin_in[1] = 1'b0;
      cyc(3);
      glitch_clr = 1'b1;
      cyc(1);
      glitch_clr = 1'b0;
      chk("clr_gc_b", d_gc[1], 8'd0);
      chk("clr_gc_c", d_gc[2], 8'd0);
      cyc(5);
      chk("clr_stay_gc_b", d_gc[1], 8'd0);

      // Reset mid-filter on instance c: partial count is discarded.
      pin_in[1] = 1'b1;
      cyc(8);
      reset = 1'b1;
      pin_in[1] = 1'b0;
      nr = 0; nf = 0;
      watch(2, 2, 1, nr, nf);
      chk("midrst_level_c1", d_level[2][1], Rv[1]);
      reset = 1'b0;
      watch(10, 2, 1, nr, nf);
      chk("midrst_pulses_c1", nr + nf, 0);
      chk("midrst_hold_c1", d_level[2][1], 1'b1);
      cyc(1);
      chk("midrst_level_after_c1", d_level[2][1], 1'b0);
      chk("midrst_fall_c1", d_fall[2][1], 1'b1);

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) pin_in[b] = ~pin_in[b];
         end
         glitch_clr = ($urandom_range(0, 63) == 0);
         reset      = ($urandom_range(0, 499) == 0);
      end
      reset      = 1'b0;
      glitch_clr = 1'b0;
      cyc(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
